// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOCK    = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JR   = 2'b01;
    localparam logic [1:0] JUMP_J    = 2'b10;
    localparam logic [1:0] JUMP_JAL  = 2'b11;

    localparam int LOCK_MAX = 2;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller with lock watchdog and sticky halt.
// Define STALL_PERF_CNT_EN to build the stall_cycles performance counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nop_lock_id,
    input  logic [1:0]  Jump_id,
    input  logic        mem_busy,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_en,
    output logic        halted,
    output logic        lock_err,
    output logic [31:0] stall_cycles
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic       w_in_halt;
    logic       w_hold;
    logic       w_lock_nxt;
    logic [1:0] w_lock_len;
    logic       r_halted;
    logic       r_lock_err;

    always_comb begin
        w_state_nxt = ST_RUN;
        if (r_state == ST_HALT || halt_req)
            w_state_nxt = ST_HALT;
        else if (mem_busy)
            w_state_nxt = ST_MEMWAIT;
        else if (nop_lock_id)
            w_state_nxt = ST_LOCK;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    assign w_in_halt    = (r_state == ST_HALT);
    assign w_hold       = w_in_halt | mem_busy | nop_lock_id;
    assign pc_en        = ~w_hold;
    assign if_id_en     = ~w_hold;
    assign id_ex_bubble = nop_lock_id & ~mem_busy & ~w_in_halt;
    assign ex_mem_en    = ~mem_busy & ~w_in_halt;
    // A jump held by a lock re-presents itself once the lock clears, so flush then.
    assign if_id_flush  = (Jump_id != JUMP_NONE) & ~w_hold;

    // Lock run length counts consecutive cycles resolving to LOCK; anything else restarts it.
    assign w_lock_nxt = (w_state_nxt == ST_LOCK);

    sat_counter #(.WIDTH(2)) u_lock_len (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (~w_lock_nxt),
        .i_inc (w_lock_nxt),
        .o_cnt (w_lock_len)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_lock_err <= 1'b0;
        else if (nop_lock_id && (w_lock_len == 2'(LOCK_MAX)))
            r_lock_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_halted <= 1'b0;
        else if (w_state_nxt == ST_HALT)
            r_halted <= 1'b1;
    end

    assign halted   = r_halted;
    assign lock_err = r_lock_err;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (1'b0),
        .i_inc (~pc_en),
        .o_cnt (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed table then randomized run vs model.
module tb_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        nop_lock_id;
    logic [1:0]  Jump_id;
    logic        mem_busy;
    logic        halt_req;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted, lock_err;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .nop_lock_id  (nop_lock_id),
        .Jump_id      (Jump_id),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_en    (ex_mem_en),
        .halted       (halted),
        .lock_err     (lock_err),
        .stall_cycles (stall_cycles)
    );

    // exp bits: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted, lock_err}
    typedef struct {
        logic       rst;
        logic       nl;
        logic       mb;
        logic       hr;
        logic [1:0] j;
        logic [6:0] exp;
        int         stall;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(logic r, logic nl, logic mb, logic hr, logic [1:0] j,
                                logic [6:0] e, int s);
        vec_t v;
        v.rst = r; v.nl = nl; v.mb = mb; v.hr = hr; v.j = j; v.exp = e; v.stall = s;
        return v;
    endfunction

    // Reference model: only "are we halted", the length of the current run of
    // lock cycles, the sticky error and the stall tally matter.
    bit      m_halt;
    int      m_run;
    bit      m_err;
    longint  m_stall;

    function automatic logic [6:0] model_out(logic nl, logic mb, logic [1:0] j);
        bit hold, pc;
        hold = m_halt || mb || nl;
        pc   = !hold;
        return {pc, pc, (j != 2'b00) && pc, nl && !mb && !m_halt, !mb && !m_halt, m_halt, m_err};
    endfunction

    task automatic model_step(logic r, logic nl, logic mb, logic hr);
        bit pc;
        pc = !(m_halt || mb || nl);
        if (r) begin
            m_halt = 0; m_run = 0; m_err = 0; m_stall = 0;
            return;
        end
        if (nl && m_run >= 2) m_err = 1;
        if (!pc && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (!m_halt && !hr && !mb && nl) m_run = (m_run < 3) ? m_run + 1 : 3;
        else m_run = 0;
        if (hr) m_halt = 1;
    endtask

    task automatic apply(logic r, logic nl, logic mb, logic hr, logic [1:0] j);
        @(negedge clk);
        rst = r; nop_lock_id = nl; mem_busy = mb; halt_req = hr; Jump_id = j;
        #1;
    endtask

    task automatic compare(string name, logic [6:0] exp, longint exp_stall);
        logic [6:0] got;
        got = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted, lock_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %b want %b", name, got, exp);
        end
        checks++;
        if (longint'(stall_cycles) != (PERF ? exp_stall : 64'd0)) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles,
                     PERF ? exp_stall : 64'd0);
        end
    endtask

    initial begin
        // Directed sequence, one row per cycle, expectations hand-derived.
        tbl[0]  = mk(0,0,0,0,2'd0, 7'b1100100, 0);
        tbl[1]  = mk(0,1,0,0,2'd0, 7'b0001100, 0);
        tbl[2]  = mk(0,1,0,0,2'd0, 7'b0001100, 1);
        tbl[3]  = mk(0,0,0,0,2'd0, 7'b1100100, 2);
        tbl[4]  = mk(0,1,1,0,2'd0, 7'b0000000, 2);
        tbl[5]  = mk(0,0,0,0,2'd0, 7'b1100100, 3);
        tbl[6]  = mk(0,1,0,0,2'd1, 7'b0001100, 3);
        tbl[7]  = mk(0,0,0,0,2'd1, 7'b1110100, 4);
        tbl[8]  = mk(0,0,0,0,2'd3, 7'b1110100, 4);
        tbl[9]  = mk(0,0,1,0,2'd2, 7'b0000000, 4);
        tbl[10] = mk(0,0,0,0,2'd0, 7'b1100100, 5);
        tbl[11] = mk(0,1,0,0,2'd0, 7'b0001100, 5);
        tbl[12] = mk(0,1,0,0,2'd0, 7'b0001100, 6);
        tbl[13] = mk(0,1,0,0,2'd0, 7'b0001100, 7);
        tbl[14] = mk(0,0,0,0,2'd0, 7'b1100101, 8);
        tbl[15] = mk(0,0,0,0,2'd0, 7'b1100101, 8);
        tbl[16] = mk(1,0,0,0,2'd0, 7'b1100101, 8);
        tbl[17] = mk(0,0,0,1,2'd0, 7'b1100100, 0);
        tbl[18] = mk(0,1,0,0,2'd0, 7'b0000010, 0);
        tbl[19] = mk(0,0,0,0,2'd0, 7'b0000010, 1);
        tbl[20] = mk(0,0,1,0,2'd3, 7'b0000010, 2);
        tbl[21] = mk(1,0,0,0,2'd0, 7'b0000010, 3);
        tbl[22] = mk(0,0,0,0,2'd0, 7'b1100100, 0);
        tbl[23] = mk(0,1,1,0,2'd0, 7'b0000000, 0);
        tbl[24] = mk(1,1,0,0,2'd0, 7'b0001100, 1);
        tbl[25] = mk(0,0,0,0,2'd0, 7'b1100100, 0);
        tbl[26] = mk(0,0,1,1,2'd0, 7'b0000000, 0);
        tbl[27] = mk(0,0,0,0,2'd0, 7'b0000010, 1);
        tbl[28] = mk(0,0,0,0,2'd0, 7'b0000010, 2);
        tbl[29] = mk(1,0,0,0,2'd0, 7'b0000010, 3);
        tbl[30] = mk(0,0,0,0,2'd0, 7'b1100100, 0);

        rst = 1'b1; nop_lock_id = 1'b0; mem_busy = 1'b0; halt_req = 1'b0; Jump_id = 2'd0;
        apply(1, 0, 0, 0, 2'd0);
        apply(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 31; i++) begin
            apply(tbl[i].rst, tbl[i].nl, tbl[i].mb, tbl[i].hr, tbl[i].j);
            compare($sformatf("row%0d", i), tbl[i].exp, longint'(tbl[i].stall));
        end

        // Randomized run against the reference model.
        apply(1, 0, 0, 0, 2'd0);
        model_step(1, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            logic r, nl, mb, hr;
            logic [1:0] j;
            r  = ($urandom_range(0, 99) < 3);
            nl = ($urandom_range(0, 99) < 45);
            mb = ($urandom_range(0, 99) < 20);
            hr = ($urandom_range(0, 99) < 3);
            j  = 2'($urandom_range(0, 3));
            apply(r, nl, mb, hr, j);
            compare($sformatf("rand%0d", c), model_out(nl, mb, j), m_stall);
            model_step(r, nl, mb, hr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL have the ports below; single clock clk; reset rst is synchronous and active-high.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 nop_lock_id  input  1  data-hazard lock request from the hazard detector, stable across the rising edge.
REQ-005 Jump_id  input  2  ID-stage jump type: 00 none, 01 jr, 10 j, 11 jal.
REQ-006 mem_busy  input  1  memory stage not done; whole pipeline must hold.
REQ-007 halt_req  input  1  syscall halt decoded in ID.
REQ-008 pc_en  output  1  PC register write enable.
REQ-009 if_id_en  output  1  IF/ID register write enable.
REQ-010 if_id_flush  output  1  clear IF/ID (kill fetched slot after a taken jump).
REQ-011 id_ex_bubble  output  1  load NOP into ID/EX instead of the ID instruction.
REQ-012 ex_mem_en  output  1  EX/MEM and MEM/WB write enable.
REQ-013 halted  output  1  sticky halt status.
REQ-014 lock_err  output  1  sticky watchdog error: hazard lock held too long.
REQ-015 stall_cycles  output  32  count of cycles with pc_en low.

Function
REQ-016 State machine states SHALL be RUN, LOCK, MEMWAIT, HALT.
REQ-017 Next state priority SHALL be: halt_req -> HALT; else mem_busy -> MEMWAIT; else nop_lock_id -> LOCK; else RUN; HALT is absorbing until rst.
REQ-018 Outputs SHALL be combinational from current state and inputs: hold = (state==HALT) | mem_busy | nop_lock_id.
REQ-019 pc_en and if_id_en SHALL equal !hold.
REQ-020 id_ex_bubble SHALL equal nop_lock_id & !mem_busy & (state!=HALT).
REQ-021 ex_mem_en SHALL equal !mem_busy & (state!=HALT).
REQ-022 if_id_flush SHALL equal (Jump_id!=00) & !hold; a jr under lock SHALL NOT flush until the lock clears.
REQ-023 halt_req together with mem_busy SHALL still enter HALT next cycle; halted SHALL be 1 from the cycle after entering HALT.
REQ-024 A 2-bit saturating lock_len SHALL increment each cycle in LOCK with nop_lock_id high, and clear on any other state.
REQ-025 lock_err SHALL set when nop_lock_id is high with lock_len==2 (third consecutive lock cycle) and stay set until rst.
REQ-026 MEMWAIT cycles SHALL NOT advance lock_len.
REQ-027 stall_cycles SHALL increment by 1 each cycle pc_en is 0, saturating at 32'hFFFF_FFFF.

Reset
REQ-028 On rst, state SHALL be RUN, lock_len 0, halted 0, lock_err 0, stall_cycles 0.
REQ-029 rst SHALL take priority over every input, including in HALT.
REQ-030 Reset mid-stall SHALL return to RUN with pc_en tracking only the current inputs on the next cycle.

Configuration
REQ-031 Macro STALL_PERF_CNT_EN defined: stall_cycles counter SHALL be implemented per REQ-027.
REQ-032 Macro STALL_PERF_CNT_EN undefined: no counter flops SHALL exist; stall_cycles SHALL be constant 0.

Structure
REQ-033 A shared package SHALL hold the state enum (2 bits), Jump_id encodings (JUMP_NONE, JUMP_JR, JUMP_J, JUMP_JAL), and LOCK_MAX=2.
REQ-034 One sub-module, sat_counter (parameterised width, saturating increment, synchronous clear), SHALL be used for lock_len and stall_cycles.

Verification
REQ-035 nop_lock_id high 2 cycles -> pc_en=0, id_ex_bubble=1 for 2 cycles, lock_err=0, stall_cycles=2.
REQ-036 nop_lock_id high 3 cycles -> lock_err=1 from the cycle after the third lock cycle and stays 1 after lock drops.
REQ-037 mem_busy and nop_lock_id both high 1 cycle -> pc_en=0, ex_mem_en=0, id_ex_bubble=0.
REQ-038 Jump_id=01 with nop_lock_id high 1 cycle, then low -> if_id_flush=0, then 1 on the following cycle.
REQ-039 halt_req pulse 1 cycle -> halted=1 onward, all enables 0, stall_cycles increments each cycle; rst -> RUN, counters 0.
REQ-040 STALL_PERF_CNT_EN undefined, 5 stall cycles -> stall_cycles stays 0.
